// File: rtl/dcache_stall_ctrl.sv
// Direct-mapped, write-back, write-allocate L1 data cache controller.
// Serves MEM-stage loads/stores from local line storage and stalls the
// pipeline while a dirty victim is written back and the line is refilled.
module dcache_stall_ctrl #(
    parameter int unsigned SETS   = 16,
    parameter int unsigned LINE_W = 256
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       cpu_addr_i,
    input  logic [31:0]       cpu_data_i,
    input  logic              cpu_MemRead_i,
    input  logic              cpu_MemWrite_i,
    output logic [31:0]       cpu_data_o,
    output logic              cpu_stall_o,
    output logic              mem_enable_o,
    output logic              mem_write_o,
    output logic [31:0]       mem_addr_o,
    output logic [LINE_W-1:0] mem_data_o,
    input  logic [LINE_W-1:0] mem_data_i,
    input  logic              mem_ack_i
);

    localparam int unsigned INDEX_W  = $clog2(SETS);
    localparam int unsigned OFFSET_W = 5;
    localparam int unsigned TAG_W    = 32 - INDEX_W - OFFSET_W;

    typedef enum logic [1:0] {
        StIdle,
        StWriteback,
        StRefill,
        StRefillDone
    } state_e;

    state_e state_q, state_d;

    // Line storage; only valid/dirty are reset.
    logic              valid_q [SETS];
    logic              dirty_q [SETS];
    logic [TAG_W-1:0]  tag_q   [SETS];
    logic [LINE_W-1:0] data_q  [SETS];

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_idx;
    logic [2:0]         addr_word;
    logic               unused_addr;

    logic               req;
    logic               is_store;
    logic               hit;
    logic [TAG_W-1:0]   line_tag;
    logic [LINE_W-1:0]  line_data;
    logic [31:0]        rd_word;
    logic [LINE_W-1:0]  store_line;
    logic               store_we;
    logic               refill_we;

    assign addr_tag    = cpu_addr_i[31 -: TAG_W];
    assign addr_idx    = cpu_addr_i[OFFSET_W +: INDEX_W];
    assign addr_word   = cpu_addr_i[4:2];
    assign unused_addr = ^cpu_addr_i[1:0];

    // A simultaneous read and write is handled as a store.
    assign req       = cpu_MemRead_i | cpu_MemWrite_i;
    assign is_store  = cpu_MemWrite_i;

    assign line_tag  = tag_q[addr_idx];
    assign line_data = data_q[addr_idx];
    assign hit       = valid_q[addr_idx] && (line_tag == addr_tag);
    assign rd_word   = line_data[{addr_word, 5'b0} +: 32];

    // Current line with the addressed word replaced by store data.
    always_comb begin
        store_line = line_data;
        store_line[{addr_word, 5'b0} +: 32] = cpu_data_i;
    end

    // Next-state and output decode; every output defaults to idle values.
    always_comb begin
        state_d      = state_q;
        cpu_stall_o  = 1'b0;
        cpu_data_o   = '0;
        mem_enable_o = 1'b0;
        mem_write_o  = 1'b0;
        mem_addr_o   = '0;
        mem_data_o   = '0;
        store_we     = 1'b0;
        refill_we    = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    if (hit) begin
                        if (is_store) begin
                            store_we = 1'b1;
                        end else begin
                            cpu_data_o = rd_word;
                        end
                    end else begin
                        cpu_stall_o = 1'b1;
                        if (valid_q[addr_idx] && dirty_q[addr_idx]) begin
                            state_d = StWriteback;
                        end else begin
                            state_d = StRefill;
                        end
                    end
                end
            end
            StWriteback: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_write_o  = 1'b1;
                mem_addr_o   = {line_tag, addr_idx, {OFFSET_W{1'b0}}};
                mem_data_o   = line_data;
                if (mem_ack_i) begin
                    state_d = StRefill;
                end
            end
            StRefill: begin
                cpu_stall_o  = 1'b1;
                mem_enable_o = 1'b1;
                mem_addr_o   = {addr_tag, addr_idx, {OFFSET_W{1'b0}}};
                if (mem_ack_i) begin
                    refill_we = 1'b1;
                    state_d   = StRefillDone;
                end
            end
            StRefillDone: begin
                // One bubble so the access is re-evaluated as a hit in idle.
                cpu_stall_o = 1'b1;
                state_d     = StIdle;
            end
            default: begin
                cpu_stall_o = 1'b1;
                state_d     = StIdle;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Valid/dirty bookkeeping; reset invalidates the whole cache.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int i = 0; i < int'(SETS); i++) begin
                valid_q[i] <= 1'b0;
                dirty_q[i] <= 1'b0;
            end
        end else if (refill_we) begin
            valid_q[addr_idx] <= 1'b1;
            dirty_q[addr_idx] <= 1'b0;
        end else if (store_we) begin
            dirty_q[addr_idx] <= 1'b1;
        end
    end

    // Tag and data arrays, written by refill or store hit.
    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            if (refill_we) begin
                tag_q[addr_idx]  <= addr_tag;
                data_q[addr_idx] <= mem_data_i;
            end else if (store_we) begin
                data_q[addr_idx] <= store_line;
            end
        end
    end

endmodule

// File: tb/tb_dcache_stall_ctrl.sv
// Directed testbench for dcache_stall_ctrl with a fixed-latency memory responder.
module tb_dcache_stall_ctrl;

    localparam int LAT = 10;

    logic         clk;
    logic         rst_i;
    logic [31:0]  cpu_addr_i;
    logic [31:0]  cpu_data_i;
    logic         cpu_MemRead_i;
    logic         cpu_MemWrite_i;
    logic [31:0]  cpu_data_o;
    logic         cpu_stall_o;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;
    logic [255:0] mem_data_i;
    logic         mem_ack_i;

    int n_vec = 0;
    int n_err = 0;

    // Responder bookkeeping.
    int           cnt = 0;
    bit           inject = 0;
    int           wb_cnt = 0;
    int           rf_cnt = 0;
    int           wr_cycles = 0;
    logic [31:0]  wb_addr = '0;
    logic [255:0] wb_data = '0;
    logic [31:0]  rf_addr = '0;

    dcache_stall_ctrl dut (
        .clk_i          (clk),
        .rst_i          (rst_i),
        .cpu_addr_i     (cpu_addr_i),
        .cpu_data_i     (cpu_data_i),
        .cpu_MemRead_i  (cpu_MemRead_i),
        .cpu_MemWrite_i (cpu_MemWrite_i),
        .cpu_data_o     (cpu_data_o),
        .cpu_stall_o    (cpu_stall_o),
        .mem_enable_o   (mem_enable_o),
        .mem_write_o    (mem_write_o),
        .mem_addr_o     (mem_addr_o),
        .mem_data_o     (mem_data_o),
        .mem_data_i     (mem_data_i),
        .mem_ack_i      (mem_ack_i)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory image: word w of the line at a is 0xA000_0000 | a | w.
    function automatic logic [255:0] line_pat(input logic [31:0] a);
        logic [255:0] l;
        for (int w = 0; w < 8; w++) begin
            l[w*32 +: 32] = 32'hA000_0000 | a | 32'(w);
        end
        return l;
    endfunction

    // Memory: acks the LAT-th consecutive enabled cycle of each request.
    initial begin
        mem_ack_i  = 1'b0;
        mem_data_i = '0;
        forever begin
            @(negedge clk);
            if (mem_enable_o && mem_write_o) wr_cycles++;
            if (inject) begin
                mem_ack_i = 1'b1;
                inject    = 0;
            end else if (mem_enable_o) begin
                cnt++;
                mem_data_i = mem_write_o ? '0 : line_pat(mem_addr_o);
                if (cnt == LAT) begin
                    mem_ack_i = 1'b1;
                    cnt       = 0;
                    if (mem_write_o) begin
                        wb_cnt++;
                        wb_addr = mem_addr_o;
                        wb_data = mem_data_o;
                    end else begin
                        rf_cnt++;
                        rf_addr = mem_addr_o;
                    end
                end else begin
                    mem_ack_i = 1'b0;
                end
            end else begin
                mem_ack_i = 1'b0;
                cnt       = 0;
            end
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    // Present a request and count stall cycles until the access completes.
    task automatic access(input logic [31:0] a, input logic [31:0] d,
                          input logic rd, input logic wr, output int stalls);
        cpu_addr_i     = a;
        cpu_data_i     = d;
        cpu_MemRead_i  = rd;
        cpu_MemWrite_i = wr;
        stalls         = 0;
        #1;
        while (cpu_stall_o && stalls < 500) begin
            stalls++;
            step();
            #1;
        end
        if (cpu_stall_o) check("stall_timeout", 32'(cpu_stall_o), 32'd0);
    endtask

    // Let the completing access take its clock edge, then drop the request.
    task automatic idle();
        step();
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
        step();
    endtask

    int s;
    int wb0, rf0, wr0;

    initial begin
        rst_i          = 1'b1;
        cpu_addr_i     = '0;
        cpu_data_i     = '0;
        cpu_MemRead_i  = 1'b0;
        cpu_MemWrite_i = 1'b0;
        do_reset();

        check("rst_stall",  32'(cpu_stall_o),  32'd0);
        check("rst_data",   cpu_data_o,        32'd0);
        check("rst_en",     32'(mem_enable_o), 32'd0);
        check("rst_wr",     32'(mem_write_o),  32'd0);
        check("rst_addr",   mem_addr_o,        32'd0);
        check("rst_mdata",  mem_data_o[31:0],  32'd0);

        // 1: clean miss, latency 10
        access(32'h0000_0040, 32'h0, 1'b1, 1'b0, s);
        check("t1_stalls",  32'(s),     32'd12);
        check("t1_rfaddr",  rf_addr,    32'h0000_0040);
        check("t1_data",    cpu_data_o, 32'hA000_0040);
        check("t1_en_idle", 32'(mem_enable_o), 32'd0);
        idle();

        // 2: store hit then load hit
        access(32'h0000_0044, 32'hDEAD_BEEF, 1'b0, 1'b1, s);
        check("t2_st_stalls", 32'(s),     32'd0);
        check("t2_st_data",   cpu_data_o, 32'd0);
        idle();
        access(32'h0000_0044, 32'h0, 1'b1, 1'b0, s);
        check("t2_ld_stalls", 32'(s),     32'd0);
        check("t2_ld_data",   cpu_data_o, 32'hDEAD_BEEF);
        idle();

        // 3: conflict miss on dirty index 2
        wb0 = wb_cnt;
        access(32'h0000_0244, 32'h0, 1'b1, 1'b0, s);
        check("t3_stalls",  32'(s),              32'd22);
        check("t3_wbcnt",   32'(wb_cnt - wb0),   32'd1);
        check("t3_wbaddr",  wb_addr,             32'h0000_0040);
        check("t3_wbw0",    wb_data[31:0],       32'hA000_0040);
        check("t3_wbw1",    wb_data[63:32],      32'hDEAD_BEEF);
        check("t3_rfaddr",  rf_addr,             32'h0000_0240);
        check("t3_data",    cpu_data_o,          32'hA000_0241);
        idle();

        // 4: store miss to a clean/invalid line
        wb0 = wb_cnt;
        wr0 = wr_cycles;
        access(32'h0000_0080, 32'hCAFE_F00D, 1'b0, 1'b1, s);
        check("t4_stalls",  32'(s),                 32'd12);
        check("t4_nowrite", 32'(wr_cycles - wr0),   32'd0);
        check("t4_rfaddr",  rf_addr,                32'h0000_0080);
        idle();
        access(32'h0000_0080, 32'h0, 1'b1, 1'b0, s);
        check("t4_ld0",     cpu_data_o, 32'hCAFE_F00D);
        check("t4_ld0_st",  32'(s),     32'd0);
        idle();
        access(32'h0000_0084, 32'h0, 1'b1, 1'b0, s);
        check("t4_ld1",     cpu_data_o, 32'hA000_0081);
        idle();
        access(32'h0000_0280, 32'h0, 1'b1, 1'b0, s);
        check("t4_ev_stalls", 32'(s),            32'd22);
        check("t4_ev_wbaddr", wb_addr,           32'h0000_0080);
        check("t4_ev_wbw0",   wb_data[31:0],     32'hCAFE_F00D);
        check("t4_ev_data",   cpu_data_o,        32'hA000_0280);
        idle();
        // Re-dirty index 4 so the post-reset check below can see dirty cleared.
        access(32'h0000_0280, 32'h5555_AAAA, 1'b0, 1'b1, s);
        idle();

        // 5: reset in the middle of a refill
        rf0            = rf_cnt;
        cpu_addr_i     = 32'h0000_0040;
        cpu_MemRead_i  = 1'b1;
        cpu_MemWrite_i = 1'b0;
        repeat (4) step();
        check("t5_in_refill", 32'(mem_enable_o), 32'd1);
        rst_i         = 1'b1;
        cpu_MemRead_i = 1'b0;
        step();
        rst_i = 1'b0;
        check("t5_en_after",    32'(mem_enable_o), 32'd0);
        check("t5_stall_after", 32'(cpu_stall_o),  32'd0);
        check("t5_addr_after",  mem_addr_o,        32'd0);
        inject = 1;
        step();
        step();
        check("t5_late_en",    32'(mem_enable_o), 32'd0);
        check("t5_late_stall", 32'(cpu_stall_o),  32'd0);
        access(32'h0000_0040, 32'h0, 1'b1, 1'b0, s);
        check("t5_reload_stalls", 32'(s),            32'd12);
        check("t5_reload_rf",     32'(rf_cnt - rf0), 32'd1);
        check("t5_reload_data",   cpu_data_o,        32'hA000_0040);
        idle();
        wb0 = wb_cnt;
        access(32'h0000_0280, 32'h0, 1'b1, 1'b0, s);
        check("t5_clr_stalls", 32'(s),            32'd12);
        check("t5_clr_nowb",   32'(wb_cnt - wb0), 32'd0);
        check("t5_clr_data",   cpu_data_o,        32'hA000_0280);
        idle();

        // 6: read+write on a hit is a store
        access(32'h0000_0044, 32'h1234_5678, 1'b1, 1'b1, s);
        check("t6_stalls", 32'(s),     32'd0);
        check("t6_data",   cpu_data_o, 32'd0);
        idle();
        access(32'h0000_0044, 32'h0, 1'b1, 1'b0, s);
        check("t6_ld",     cpu_data_o, 32'h1234_5678);
        idle();
        step();
        check("end_stall", 32'(cpu_stall_o),  32'd0);
        check("end_en",    32'(mem_enable_o), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Global time bound.
    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
